issue_sched: RTL and testbench

Issue scheduler between the execution queues (integer, multiplier, divider) and their functional units. Each cycle it grants at most one ready queue, asserting that queue's `issue*_done` so the queue pops its selected entry. Grants follow fixed priority, a CDB-slot reservation shift register, and a divider busy counter, so no two results ever collide on the common data bus. It also drives the per-cycle CDB source select used by the CDB mux.

---
 rtl/issue_sched_pkg.sv | 17 +
 rtl/cdb_slot_shreg.sv | 46 ++++
 rtl/issue_sched.sv | 110 +++++++++++
 tb/tb_issue_sched.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/issue_sched_pkg.sv
// Shared definitions for the issue scheduler: CDB source codes, default unit
// latencies and the CDB reservation slot entry.
package issue_sched_pkg;

  localparam logic [1:0] SRC_INT  = 2'd0;
  localparam logic [1:0] SRC_MULT = 2'd1;
  localparam logic [1:0] SRC_DIV  = 2'd2;

  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 6;

  typedef struct packed {
    logic       valid;
    logic [1:0] src;
  } slot_t;

endpackage

// File: rtl/cdb_slot_shreg.sv
// CDB reservation shift register: entry k books the bus k cycles from now.
// Shifts toward entry 0 every edge; a booking lands at its post-shift index.
module cdb_slot_shreg
  import issue_sched_pkg::*;
#(
  parameter int DEPTH = DIV_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
  input  logic [1:0]               wr_src_i,
  output logic [DEPTH:0]           slot_v_o,
  output slot_t                    head_o
);

  localparam int IW = $clog2(DEPTH);

  slot_t [DEPTH-1:0] slot_q;
  slot_t [DEPTH-1:0] slot_d;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    slot_t shifted;
    if (gi == DEPTH - 1) begin : g_top
      assign shifted = '0;
    end else begin : g_mid
      assign shifted = slot_q[gi+1];
    end
    assign slot_d[gi]   = (wr_en_i && (wr_idx_i == IW'(gi))) ? slot_t'{valid: 1'b1, src: wr_src_i}
                                                              : shifted;
    assign slot_v_o[gi] = slot_q[gi].valid;
  end

  // One past the top is never booked, so the divider always sees a free slot.
  assign slot_v_o[DEPTH] = 1'b0;
  assign head_o          = slot_q[0];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/issue_sched.sv
// Issue scheduler: grants at most one ready queue per cycle so that results
// from the integer, multiplier and divider units never collide on the CDB.
module issue_sched
  import issue_sched_pkg::*;
#(
  parameter int MULT_LAT   = MULT_LAT_DEF,
  parameter int DIV_LAT    = DIV_LAT_DEF,
  parameter int STARVE_MAX = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issueint_ready,
  input  logic       issuemult_ready,
  input  logic       issuediv_ready,
  output logic       issueint_done,
  output logic       issuemult_done,
  output logic       issuediv_done,
  output logic       cdb_grant_valid,
  output logic [1:0] cdb_grant_src
);

  localparam int IW = $clog2(DIV_LAT);
  localparam int CW = $clog2(DIV_LAT);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [DIV_LAT:0] slot_v;
  slot_t            head;
  logic             slot_v_unused;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [SW-1:0] int_wait_q, int_wait_d;

  logic          int_elig, mult_elig, div_elig, starved;
  logic          grant_int, grant_mult, grant_div;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [1:0]    wr_src;

  // A unit with latency L writes post-shift index L-1, i.e. pre-shift index L.
  assign int_elig  = issueint_ready & ~slot_v[1];
  assign mult_elig = issuemult_ready & ~slot_v[MULT_LAT];
  assign div_elig  = issuediv_ready & ~slot_v[DIV_LAT] & (div_cnt_q == '0);
  assign starved   = (int_wait_q == SW'(STARVE_MAX));

  always_comb begin
    grant_int  = 1'b0;
    grant_mult = 1'b0;
    grant_div  = 1'b0;
    // A starved integer queue blocks everyone else until its slot drains.
    if (starved)        grant_int  = int_elig;
    else if (div_elig)  grant_div  = 1'b1;
    else if (mult_elig) grant_mult = 1'b1;
    else                grant_int  = int_elig;
  end

  always_comb begin
    wr_en  = grant_int | grant_mult | grant_div;
    wr_idx = '0;
    wr_src = SRC_INT;
    if (grant_div) begin
      wr_idx = IW'(DIV_LAT - 1);
      wr_src = SRC_DIV;
    end else if (grant_mult) begin
      wr_idx = IW'(MULT_LAT - 1);
      wr_src = SRC_MULT;
    end
  end

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (grant_div)              div_cnt_d = CW'(DIV_LAT - 1);
    else if (div_cnt_q != '0)   div_cnt_d = div_cnt_q - 1'b1;
    int_wait_d = '0;
    if (issueint_ready && !grant_int) begin
      int_wait_d = starved ? int_wait_q : int_wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q  <= '0;
      int_wait_q <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      int_wait_q <= int_wait_d;
    end
  end

  cdb_slot_shreg #(
    .DEPTH (DIV_LAT)
  ) u_slots (
    .clk      (clk),
    .rst_ni   (reset),
    .wr_en_i  (wr_en),
    .wr_idx_i (wr_idx),
    .wr_src_i (wr_src),
    .slot_v_o (slot_v),
    .head_o   (head)
  );

  assign slot_v_unused = ^slot_v;

  // Grants are held low while reset is asserted, even with ready inputs high.
  assign issueint_done   = grant_int & reset;
  assign issuemult_done  = grant_mult & reset;
  assign issuediv_done   = grant_div & reset;
  assign cdb_grant_valid = head.valid;
  assign cdb_grant_src   = head.src;

endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched: expected CDB bookings are queued when a
// grant is expected and retired in the cycle the bus should carry them.
module tb_issue_sched;
  import issue_sched_pkg::*;

  logic       clk;
  logic       reset;
  logic       issueint_ready, issuemult_ready, issuediv_ready;
  logic       issueint_done, issuemult_done, issuediv_done;
  logic       cdb_grant_valid;
  logic [1:0] cdb_grant_src;

  typedef struct {
    int         cyc;
    logic [1:0] src;
  } cdb_exp_t;

  cdb_exp_t cdb_q[$];
  int       cyc    = 0;
  int       checks = 0;
  int       errors = 0;

  issue_sched dut (
    .clk             (clk),
    .reset           (reset),
    .issueint_ready  (issueint_ready),
    .issuemult_ready (issuemult_ready),
    .issuediv_ready  (issuediv_ready),
    .issueint_done   (issueint_done),
    .issuemult_done  (issuemult_done),
    .issuediv_done   (issuediv_done),
    .cdb_grant_valid (cdb_grant_valid),
    .cdb_grant_src   (cdb_grant_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // One cycle: drive ready {div,mult,int}, check grants and the CDB head,
  // then book the CDB results implied by the expected grants.
  task automatic step(input logic [2:0] rdy, input logic [2:0] exp_done, input string tag);
    logic [2:0] exp_cdb;
    int         hit;
    @(negedge clk);
    {issuediv_ready, issuemult_ready, issueint_ready} = rdy;
    #1;
    check({tag, " done"}, {issuediv_done, issuemult_done, issueint_done}, exp_done);
    exp_cdb = 3'b000;
    hit     = -1;
    foreach (cdb_q[i]) begin
      if (hit < 0 && cdb_q[i].cyc == cyc) hit = i;
    end
    if (hit >= 0) begin
      exp_cdb = {1'b1, cdb_q[hit].src};
      cdb_q.delete(hit);
    end
    check({tag, " cdb"}, {cdb_grant_valid, cdb_grant_src}, exp_cdb);
    if (exp_done[2]) cdb_q.push_back('{cyc + DIV_LAT_DEF, SRC_DIV});
    if (exp_done[1]) cdb_q.push_back('{cyc + MULT_LAT_DEF, SRC_MULT});
    if (exp_done[0]) cdb_q.push_back('{cyc + 1, SRC_INT});
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(3'b000, 3'b000, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {issuediv_ready, issuemult_ready, issueint_ready} = 3'b111;
    #1 reset = 1'b0;
    #2;
    check("reset cdb", {cdb_grant_valid, cdb_grant_src}, 3'b000);
    check("reset done", {issuediv_done, issuemult_done, issueint_done}, 3'b000);
    @(negedge clk);
    {issuediv_ready, issuemult_ready, issueint_ready} = 3'b000;
    @(negedge clk);
    reset = 1'b1;
    idle(2, "post-reset");

    // All three ready: div, then mult, then int.
    step(3'b111, 3'b100, "all3 t");
    step(3'b011, 3'b010, "all3 t+1");
    step(3'b001, 3'b001, "all3 t+2");
    idle(7, "all3 drain");

    // Multiplier booking blocks the integer slot at t+3.
    step(3'b010, 3'b010, "conflict t");
    idle(2, "conflict gap");
    step(3'b001, 3'b000, "conflict t+3");
    step(3'b001, 3'b001, "conflict t+4");
    idle(4, "conflict drain");

    // Divider held ready: one grant every DIV_LAT cycles.
    for (int i = 0; i < 13; i++) begin
      step(3'b100, (i % DIV_LAT_DEF == 0) ? 3'b100 : 3'b000, "divbusy");
    end
    idle(7, "divbusy drain");

    // Starvation: mult wins three times, then bus drains for integer.
    for (int i = 0; i < 3; i++) step(3'b011, 3'b010, "starve mult");
    for (int i = 0; i < 3; i++) step(3'b011, 3'b000, "starve hold");
    step(3'b011, 3'b001, "starve int");
    step(3'b011, 3'b010, "starve resume");
    step(3'b001, 3'b001, "starve int2");
    idle(7, "starve drain");

    idle(20, "no request");

    // Reset in the middle of a cycle with bookings in flight.
    step(3'b100, 3'b100, "rst div");
    step(3'b010, 3'b010, "rst mult");
    step(3'b001, 3'b001, "rst int");
    step(3'b000, 3'b000, "rst cdb int");
    #2;
    {issuediv_ready, issuemult_ready, issueint_ready} = 3'b111;
    reset = 1'b0;
    #1;
    check("midrst cdb", {cdb_grant_valid, cdb_grant_src}, 3'b000);
    check("midrst done", {issuediv_done, issuemult_done, issueint_done}, 3'b000);
    cdb_q.delete();
    @(negedge clk);
    {issuediv_ready, issuemult_ready, issueint_ready} = 3'b000;
    reset = 1'b1;
    idle(DIV_LAT_DEF, "after rst");
    step(3'b100, 3'b100, "after rst div");
    idle(7, "final drain");

    checks++;
    assert (cdb_q.size() == 0)
    else begin
      errors++;
      $error("FAIL drain: observed %0d pending expected 0", cdb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
